dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 12, RAM word-address width.
REQ-002 SHALL have parameter DEPTH, default 4096, RAM words; DEPTH = 2**ADDRESS_WIDTH.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of 2, at least 2).
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port wren  input  1  processor store strobe.
REQ-007 SHALL have port address_dmem  input  32  processor word address.
REQ-008 SHALL have port data  input  32  processor store data.
REQ-009 SHALL have port q_dmem  output  32  registered load data to processor.
REQ-010 SHALL have port tx_valid  output  1  TX FIFO head valid.
REQ-011 SHALL have port tx_data  output  32  TX FIFO head word.
REQ-012 SHALL have port tx_ready  input  1  downstream accepts head.
REQ-013 SHALL have port rx_valid_in  input  1  upstream word offered.
REQ-014 SHALL have port rx_data_in  input  32  upstream word.
REQ-015 SHALL have port rx_ready  output  1  RX holding register empty.

Function
REQ-016 SHALL decode address_dmem[ADDRESS_WIDTH] = 0 as RAM (index address_dmem[ADDRESS_WIDTH-1:0]) and = 1 as MMIO (offset address_dmem[3:0]); higher bits are ignored.
REQ-017 SHALL write data into RAM at the rising edge when wren=1 and the access targets RAM; RAM contents are not reset.
REQ-018 SHALL register q_dmem at every rising edge from the address sampled at that edge; the load result is valid after edge k for an address presented before edge k (1-cycle latency).
REQ-019 SHALL return the old RAM word on read-during-write to the same address.
REQ-020 SHALL implement MMIO 0x0 STATUS (read-only): bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 overflow, bits 7:4 TX count (saturating at 15), others 0.
REQ-021 SHALL implement MMIO 0x1 TX_DATA: a write pushes data into the TX FIFO; reads return 0.
REQ-022 SHALL accept a TX push when the FIFO is not full, or when it is full and a pop occurs at the same edge; otherwise SHALL drop the word and set overflow.
REQ-023 SHALL pop the TX FIFO at an edge where tx_valid=1 and tx_ready=1; tx_valid = not empty; tx_data = head word, FIFO order preserved; pointers wrap modulo FIFO_DEPTH.
REQ-024 SHALL implement MMIO 0x2 RX_DATA: a read returns the holding register and clears rx_full at that edge; when rx_full=0 a read returns 0 and has no side effect.
REQ-025 SHALL drive rx_ready = reset deasserted AND NOT rx_full; SHALL capture rx_data_in and set rx_full at an edge with rx_valid_in=1 and rx_ready=1.
REQ-026 SHALL give a simultaneous RX_DATA read and offered word no capture in that cycle (rx_ready was 0); capture occurs on a later edge.
REQ-027 SHALL implement MMIO 0x3 CYCLES (read-only): free-running 32-bit counter, +1 per edge, wrapping 0xFFFFFFFF to 0.
REQ-028 SHALL implement MMIO 0x4 ERR: read returns {31'b0, overflow}; any write clears overflow, with a write taking priority over a same-edge overflow set.
REQ-029 SHALL return 0 on reads of unmapped MMIO offsets and ignore writes to them.
REQ-030 SHALL ignore wren for read-only MMIO registers.

Reset
REQ-031 SHALL, while reset=0, asynchronously force q_dmem=0, TX FIFO empty (tx_valid=0, tx_data=0), rx_full=0, rx_ready=0, overflow=0, CYCLES=0.
REQ-032 SHALL apply reset mid-operation such that all pending TX words are discarded and an in-flight load returns 0; normal operation resumes on the first edge after reset=1.

Verification
REQ-033 SHALL have a bench scenario: store 0x12345678 to RAM 0x005, then load 0x005 -> q_dmem=0x12345678 one edge after the load address is sampled; load 0x006 unwritten while writing 0x006 -> old value.
REQ-034 SHALL have a bench scenario: tx_ready=0, write 9 words 1..9 to TX_DATA (FIFO_DEPTH 8) -> STATUS=0x0000008D (count 8, tx_full, overflow); raise tx_ready -> tx_data 1..8 in order, then tx_valid=0.
REQ-035 SHALL have a bench scenario: FIFO full with tx_ready=1 and TX write of 0xAA at the same edge -> push accepted, no overflow, 0xAA emerges last.
REQ-036 SHALL have a bench scenario: rx_valid_in=1 with 0xCAFE -> rx_ready falls, STATUS bit2=1; RX_DATA read -> 0xCAFE, bit2=0; second read -> 0.
REQ-037 SHALL have a bench scenario: pull reset low with 3 TX words queued and CYCLES=100 -> tx_valid=0, CYCLES reads 1 on the first read after release, RAM contents preserved.
REQ-038 SHALL have a bench scenario: ERR write with a simultaneous overflowing push -> overflow=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO window holding a TX FIFO, an RX
// holding register, a free-running cycle counter and a sticky TX overflow flag.
module dmem_responder #(
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned DEPTH         = 4096,
    parameter int unsigned FIFO_DEPTH    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    output logic [31:0] q_dmem,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid_in,
    input  logic [31:0] rx_data_in,
    output logic        rx_ready
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [3:0] OFF_STATUS = 4'h0;
    localparam logic [3:0] OFF_TX     = 4'h1;
    localparam logic [3:0] OFF_RX     = 4'h2;
    localparam logic [3:0] OFF_CYCLES = 4'h3;
    localparam logic [3:0] OFF_ERR    = 4'h4;

    // Address decode
    logic                     is_mmio_c;
    logic [3:0]               offset_c;
    logic [ADDRESS_WIDTH-1:0] ram_index_c;
    logic                     unused_addr_c;

    assign is_mmio_c     = address_dmem[ADDRESS_WIDTH];
    assign offset_c      = address_dmem[3:0];
    assign ram_index_c   = address_dmem[ADDRESS_WIDTH-1:0];
    assign unused_addr_c = ^address_dmem[WORD_W-1:ADDRESS_WIDTH+1];

    logic ram_we_c;
    logic tx_push_c;
    logic err_wr_c;
    logic rx_rd_c;

    assign ram_we_c  = wren & ~is_mmio_c;
    assign tx_push_c = wren & is_mmio_c & (offset_c == OFF_TX);
    assign err_wr_c  = wren & is_mmio_c & (offset_c == OFF_ERR);
    // Any access to RX_DATA is a load and consumes the held word
    assign rx_rd_c   = is_mmio_c & (offset_c == OFF_RX);

    // RAM: no reset, old data on read-during-write comes from the q_dmem register
    logic [WORD_W-1:0] ram [DEPTH];

    always_ff @(posedge clock) begin
        if (ram_we_c) begin
            ram[ram_index_c] <= data;
        end
    end

    // TX FIFO state
    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  tx_count;
    logic              overflow;

    logic tx_full_c;
    logic tx_empty_c;
    logic tx_pop_c;
    logic tx_accept_c;
    logic overflow_set_c;

    assign tx_full_c      = (tx_count == CNT_W'(FIFO_DEPTH));
    assign tx_empty_c     = (tx_count == '0);
    assign tx_pop_c       = tx_valid & tx_ready;
    // A full FIFO still takes a push when the head leaves on the same edge
    assign tx_accept_c    = tx_push_c & (~tx_full_c | tx_pop_c);
    assign overflow_set_c = tx_push_c & ~tx_accept_c;

    assign tx_valid = ~tx_empty_c;
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (tx_accept_c) begin
            fifo_mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_count <= '0;
        end else begin
            if (tx_accept_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (tx_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({tx_accept_c, tx_pop_c})
                2'b10:   tx_count <= tx_count + CNT_W'(1);
                2'b01:   tx_count <= tx_count - CNT_W'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // Sticky overflow; an ERR write wins over a same-edge set
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (err_wr_c) begin
            overflow <= 1'b0;
        end else if (overflow_set_c) begin
            overflow <= 1'b1;
        end
    end

    // RX holding register
    logic              rx_full;
    logic [WORD_W-1:0] rx_hold;

    assign rx_ready = reset & ~rx_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_full <= 1'b0;
            rx_hold <= '0;
        end else if (rx_rd_c && rx_full) begin
            rx_full <= 1'b0;
        end else if (rx_valid_in && rx_ready) begin
            rx_full <= 1'b1;
            rx_hold <= rx_data_in;
        end
    end

    // Free-running cycle counter
    logic [WORD_W-1:0] cycles;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + WORD_W'(1);
        end
    end

    // STATUS word with saturating TX occupancy
    logic [3:0]        tx_count_sat_c;
    logic [WORD_W-1:0] status_c;

    always_comb begin
        tx_count_sat_c = 4'hF;
        if (32'(tx_count) < 32'd15) begin
            tx_count_sat_c = 4'(tx_count);
        end
    end

    assign status_c = {24'h0, tx_count_sat_c, overflow, rx_full, tx_empty_c, tx_full_c};

    // Load mux; CYCLES returns the count as it stands after this edge
    logic [WORD_W-1:0] read_word_c;

    always_comb begin
        read_word_c = '0;
        if (!is_mmio_c) begin
            read_word_c = ram[ram_index_c];
        end else begin
            case (offset_c)
                OFF_STATUS: read_word_c = status_c;
                OFF_RX:     read_word_c = rx_full ? rx_hold : '0;
                OFF_CYCLES: read_word_c = cycles + WORD_W'(1);
                OFF_ERR:    read_word_c = {31'h0, overflow};
                default:    read_word_c = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_dmem <= '0;
        end else begin
            q_dmem <= read_word_c;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the memory map.
module tb_dmem_responder;
    localparam int unsigned AW = 12;
    localparam int unsigned FD = 8;

    localparam logic [3:0] O_STATUS = 4'h0;
    localparam logic [3:0] O_TX     = 4'h1;
    localparam logic [3:0] O_RX     = 4'h2;
    localparam logic [3:0] O_CYC    = 4'h3;
    localparam logic [3:0] O_ERR    = 4'h4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_dmem;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        rx_valid_in;
    logic [31:0] rx_data_in;
    logic        rx_ready;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    logic [31:0] m_ram    [1<<AW];
    bit          m_ram_ok [1<<AW];
    logic [31:0] m_tx [$];
    bit          m_rx_full;
    logic [31:0] m_rx_hold;
    bit          m_ovf;
    logic [31:0] m_cycles;

    always #5 clock = ~clock;

    dmem_responder #(
        .ADDRESS_WIDTH(AW),
        .DEPTH        (1 << AW),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wren        (wren),
        .address_dmem(address_dmem),
        .data        (data),
        .q_dmem      (q_dmem),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .rx_valid_in (rx_valid_in),
        .rx_data_in  (rx_data_in),
        .rx_ready    (rx_ready)
    );

    function automatic logic [31:0] ram_addr(input int unsigned idx);
        return 32'(idx % (1 << AW));
    endfunction

    function automatic logic [31:0] mmio_addr(input logic [3:0] off);
        return 32'h0000_1000 | {28'h0, off};
    endfunction

    function automatic logic [31:0] model_status();
        int unsigned n;
        n = m_tx.size();
        return {24'h0, 4'((n > 15) ? 15 : n), m_ovf, m_rx_full, (n == 0), (n == FD)};
    endfunction

    task automatic model_reset();
        m_tx.delete();
        m_rx_full = 1'b0;
        m_rx_hold = 32'h0;
        m_ovf     = 1'b0;
        m_cycles  = 32'h0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge: predict from the current inputs, then compare after the edge
    task automatic tick();
        logic [31:0] exp_q;
        bit          exp_ok;
        bit          mm;
        logic [3:0]  off;
        int unsigned idx;
        mm     = address_dmem[AW];
        off    = address_dmem[3:0];
        idx    = 32'(address_dmem[AW-1:0]);
        exp_q  = 32'h0;
        exp_ok = 1'b1;
        if (!mm) begin
            exp_q  = m_ram[idx];
            exp_ok = m_ram_ok[idx];
        end else begin
            case (off)
                O_STATUS: exp_q = model_status();
                O_RX:     exp_q = m_rx_full ? m_rx_hold : 32'h0;
                O_CYC:    exp_q = m_cycles + 32'd1;
                O_ERR:    exp_q = {31'h0, m_ovf};
                default:  exp_q = 32'h0;
            endcase
        end
        if (m_tx.size() != 0 && tx_ready) void'(m_tx.pop_front());
        if (wren && mm && off == O_TX) begin
            if (m_tx.size() < FD) m_tx.push_back(data);
            else m_ovf = 1'b1;
        end
        if (wren && mm && off == O_ERR) m_ovf = 1'b0;
        if (wren && !mm) begin
            m_ram[idx]    = data;
            m_ram_ok[idx] = 1'b1;
        end
        if (mm && off == O_RX && m_rx_full) m_rx_full = 1'b0;
        else if (rx_valid_in && !m_rx_full) begin
            m_rx_full = 1'b1;
            m_rx_hold = rx_data_in;
        end
        m_cycles = m_cycles + 32'd1;
        @(posedge clock);
        #1;
        if (exp_ok) check("q_dmem", q_dmem, exp_q);
        check("tx_valid", 32'(tx_valid), 32'(m_tx.size() != 0));
        check("tx_data", tx_data, (m_tx.size() != 0) ? m_tx[0] : 32'h0);
        check("rx_ready", 32'(rx_ready), 32'(!m_rx_full));
    endtask

    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
        wren         = w;
        address_dmem = a;
        data         = d;
        tick();
    endtask

    initial begin
        logic [31:0] popped [$];
        wren = 1'b0; address_dmem = 32'h0; data = 32'h0;
        tx_ready = 1'b0; rx_valid_in = 1'b0; rx_data_in = 32'h0;
        model_reset();

        // Power-on reset
        #1 reset = 1'b0;
        #1;
        check("rst_q", q_dmem, 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data", tx_data, 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h0);
        #10 reset = 1'b1;

        // RAM store/load and read-during-write
        step(1'b1, ram_addr(5), 32'h1234_5678);
        step(1'b0, ram_addr(5), 32'h0);
        check("ram_load", q_dmem, 32'h1234_5678);
        step(1'b1, ram_addr(6), 32'h1111_1111);
        step(1'b1, ram_addr(6), 32'h2222_2222);
        check("rdw_old", q_dmem, 32'h1111_1111);
        step(1'b0, ram_addr(6), 32'h0);
        check("rdw_new", q_dmem, 32'h2222_2222);
        step(1'b1, ram_addr(7), 32'h7777_7777);
        checks++;
        assert (q_dmem !== 32'h7777_7777) else begin
            errors++;
            $error("FAIL rdw_unwritten observed=0x%08h expected=not 0x77777777", q_dmem);
        end

        // Park a word in RX so STATUS shows rx_full during the TX tests
        rx_data_in = 32'h5A5A; rx_valid_in = 1'b1;
        step(1'b0, ram_addr(5), 32'h0);
        rx_valid_in = 1'b0;
        check("rx_ready_low", 32'(rx_ready), 32'h0);

        // Nine pushes into an eight-deep FIFO
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) step(1'b1, mmio_addr(O_TX), 32'(i));
        step(1'b0, mmio_addr(O_STATUS), 32'h0);
        check("status_full_ovf", q_dmem, 32'h0000_008D);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("tx_order", tx_data, 32'(i));
            step(1'b0, ram_addr(5), 32'h0);
        end
        check("tx_drained", 32'(tx_valid), 32'h0);
        step(1'b1, mmio_addr(O_ERR), 32'h0);
        step(1'b0, mmio_addr(O_ERR), 32'h0);
        check("err_cleared", q_dmem, 32'h0);

        // Push into a full FIFO on the same edge as a pop
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, mmio_addr(O_TX), 32'h10 + 32'(i));
        tx_ready = 1'b1;
        step(1'b1, mmio_addr(O_TX), 32'hAA);
        tx_ready = 1'b0;
        step(1'b0, mmio_addr(O_ERR), 32'h0);
        check("err_full_pop_push", q_dmem, 32'h0);
        step(1'b0, mmio_addr(O_STATUS), 32'h0);
        check("status_full_no_ovf", q_dmem, 32'h0000_0085);
        tx_ready = 1'b1;
        for (int n = 0; n < 16 && tx_valid; n++) begin
            popped.push_back(tx_data);
            step(1'b0, ram_addr(5), 32'h0);
        end
        check("drain_count", 32'(popped.size()), 32'd8);
        check("drain_first", (popped.size() != 0) ? popped[0] : 32'h0, 32'h11);
        check("drain_last", (popped.size() != 0) ? popped[$] : 32'h0, 32'hAA);

        // RX holding register
        step(1'b0, mmio_addr(O_RX), 32'h0);
        check("rx_parked", q_dmem, 32'h5A5A);
        rx_data_in = 32'hCAFE; rx_valid_in = 1'b1;
        step(1'b0, ram_addr(5), 32'h0);
        rx_valid_in = 1'b0;
        check("rx_ready_fell", 32'(rx_ready), 32'h0);
        step(1'b0, mmio_addr(O_STATUS), 32'h0);
        check("status_rx_full", (q_dmem >> 2) & 32'h1, 32'h1);
        step(1'b0, mmio_addr(O_RX), 32'h0);
        check("rx_cafe", q_dmem, 32'hCAFE);
        step(1'b0, mmio_addr(O_STATUS), 32'h0);
        check("status_rx_clear", (q_dmem >> 2) & 32'h1, 32'h0);
        step(1'b0, mmio_addr(O_RX), 32'h0);
        check("rx_empty_read", q_dmem, 32'h0);

        // Read and offer on the same edge: capture waits one edge
        rx_data_in = 32'hBEEF; rx_valid_in = 1'b1;
        step(1'b0, ram_addr(5), 32'h0);
        rx_data_in = 32'hD00D;
        step(1'b0, mmio_addr(O_RX), 32'h0);
        check("rx_beef", q_dmem, 32'hBEEF);
        check("rx_ready_after_read", 32'(rx_ready), 32'h1);
        step(1'b0, ram_addr(5), 32'h0);
        rx_valid_in = 1'b0;
        step(1'b0, mmio_addr(O_RX), 32'h0);
        check("rx_d00d", q_dmem, 32'hD00D);

        // Reset mid-operation with TX words queued
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, mmio_addr(O_TX), 32'h31 + 32'(i));
        while (m_cycles < 32'd99) step(1'b0, ram_addr(5), 32'h0);
        step(1'b0, mmio_addr(O_CYC), 32'h0);
        check("cycles_100", q_dmem, 32'd100);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("mid_rst_q", q_dmem, 32'h0);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
        check("mid_rst_tx_data", tx_data, 32'h0);
        check("mid_rst_rx_ready", 32'(rx_ready), 32'h0);
        repeat (2) @(posedge clock);
        #3;
        check("held_rst_q", q_dmem, 32'h0);
        wren = 1'b0; address_dmem = mmio_addr(O_CYC); data = 32'h0;
        reset = 1'b1;
        tick();
        check("cycles_after_reset", q_dmem, 32'd1);
        step(1'b0, ram_addr(5), 32'h0);
        check("ram_kept", q_dmem, 32'h1234_5678);

        // Overflow then ERR write
        for (int i = 0; i < 8; i++) step(1'b1, mmio_addr(O_TX), 32'h40 + 32'(i));
        step(1'b1, mmio_addr(O_TX), 32'hEE);
        step(1'b0, mmio_addr(O_ERR), 32'h0);
        check("err_set", q_dmem, 32'h1);
        step(1'b1, mmio_addr(O_ERR), 32'h0);
        step(1'b0, mmio_addr(O_ERR), 32'h0);
        check("err_write_clear", q_dmem, 32'h0);

        // Random traffic, upper address bits randomised
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            logic [31:0] a;
            logic        w;
            r = $urandom;
            if (r[0]) a = {r[31:13], 1'b0, 7'h0, r[5:1]};
            else a = {r[31:13], 1'b1, r[11:4], 4'($urandom_range(0, 7))};
            w           = ($urandom_range(0, 2) == 0);
            tx_ready    = 1'($urandom_range(0, 1));
            rx_valid_in = 1'($urandom_range(0, 1));
            rx_data_in  = $urandom;
            step(w, a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
